// File: rtl/hs_master_retry.sv
`default_nettype none
// ============================================================================
// Module      : hs_master_retry
// Description : Bus master for the valid/ready/response handshake link.
//               Takes one word at a time from an upstream producer, presents
//               it on the bus with a stable valid/data handshake, then waits
//               for the slave's response. A nack or a response timeout
//               causes the same word to be resent, up to MAX_RETRY extra
//               attempts. The final outcome is reported as a one-cycle done
//               (acknowledged) or fail (abandoned) pulse.
//
// Parameters  : DATA_W    - bus / request data width (>= 1)
//               MAX_RETRY - retransmissions after the first attempt (>= 0)
//               TIMEOUT   - WAIT_RESP cycles before an attempt fails (>= 2)
//
// Ports       : clk        - clock, all state on the rising edge
//               reset      - asynchronous active-high reset
//               req_valid  - upstream word available
//               req_ready  - block can accept a word (IDLE only)
//               req_data   - upstream word
//               valid      - bus word valid
//               ready      - slave accepts the bus word
//               dout       - bus word
//               response   - slave response strobe
//               resp_err   - response qualifier: 1 = nack, 0 = ack
//               done       - one-cycle pulse, word acknowledged
//               fail       - one-cycle pulse, word abandoned
//               retry_cnt  - retransmissions used by the current/last word
//
// Revision    : 1.0 - initial release
// ============================================================================
module hs_master_retry #(
    parameter  int DATA_W    = 32,
    parameter  int MAX_RETRY = 3,
    parameter  int TIMEOUT   = 16,
    // retry_cnt must be at least one bit wide even when MAX_RETRY is 0
    localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,

    // Upstream request side
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_data,

    // Bus side
    output logic                valid,
    input  logic                ready,
    output logic [DATA_W-1:0]   dout,
    input  logic                response,
    input  logic                resp_err,

    // Per-word status
    output logic                done,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_SEND      = 2'd1;
    localparam logic [1:0] c_WAIT_RESP = 2'd2;

    localparam logic [RETRY_W-1:0] c_RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] c_RETRY_ONE  = RETRY_W'(1);
    localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_TIMER_ONE  = TIMER_W'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [DATA_W-1:0]   r_hold;
    logic [RETRY_W-1:0]  r_retry_cnt;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_done;
    logic                r_fail;

    // ------------------------------------------------------------------------
    // Decode of the events that move the FSM
    // ------------------------------------------------------------------------
    logic w_in_idle;
    logic w_in_send;
    logic w_in_wait;
    logic w_accept;
    logic w_xfer;
    logic w_ack;
    logic w_nack;
    logic w_timeout;
    logic w_attempt_fail;
    logic w_retries_left;
    logic w_give_up;
    logic w_retry;

    assign w_in_idle = (r_state == c_IDLE);
    assign w_in_send = (r_state == c_SEND);
    assign w_in_wait = (r_state == c_WAIT_RESP);

    // While reset is high the flops are held anyway, so accept does not need
    // to look at reset; only the visible req_ready is gated by it.
    assign w_accept  = w_in_idle & req_valid;
    assign w_xfer    = w_in_send & ready;

    // Responses only count in WAIT_RESP; anything seen in IDLE or SEND is
    // dropped by these qualifiers.
    assign w_ack     = w_in_wait & response & ~resp_err;
    assign w_nack    = w_in_wait & response &  resp_err;

    // A response in the last timer cycle wins over the timeout.
    assign w_timeout = w_in_wait & ~response & (r_timer == c_TIMER_LAST);

    assign w_attempt_fail = w_nack | w_timeout;

    // retry_cnt never passes MAX_RETRY, so inequality is enough to decide
    // whether another attempt is allowed.
    assign w_retries_left = (r_retry_cnt != c_RETRY_LAST);
    assign w_give_up      = w_attempt_fail & ~w_retries_left;
    assign w_retry        = w_attempt_fail &  w_retries_left;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                if (w_xfer) begin
                    w_state_nxt = c_WAIT_RESP;
                end
            end
            c_WAIT_RESP: begin
                if (w_ack || w_give_up) begin
                    w_state_nxt = c_IDLE;
                end else if (w_retry) begin
                    w_state_nxt = c_SEND;
                end
            end
            default: begin
                // Unused encoding: fall back to a safe idle state
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Hold register: captured on accept, unchanged through every retry so
    // each retransmission carries the identical word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= req_data;
        end
    end

    // ------------------------------------------------------------------------
    // Retry counter: cleared on accept, bumped on each retransmission, and
    // left alone after done/fail so the producer can read the final count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry_cnt <= '0;
        end else if (w_accept) begin
            r_retry_cnt <= '0;
        end else if (w_retry) begin
            r_retry_cnt <= r_retry_cnt + c_RETRY_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Response timer: restarted on every bus transfer, so it counts from 0 in
    // the first WAIT_RESP cycle and reaches TIMEOUT-1 in the TIMEOUT-th. The
    // FSM always leaves WAIT_RESP at that point, so the counter cannot wrap.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_xfer) begin
            r_timer <= '0;
        end else if (w_in_wait) begin
            r_timer <= r_timer + c_TIMER_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Status pulses: registered, high only for the cycle after the deciding
    // edge. ack and give-up are mutually exclusive, so done and fail can
    // never be high together.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            r_done <= w_ack;
            r_fail <= w_give_up;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // req_ready is forced low during reset so nothing upstream sees a
    // handshake while the block is being cleared.
    assign req_ready = w_in_idle & ~reset;
    assign valid     = w_in_send;
    // dout follows the hold register directly, so it is stable for the whole
    // time valid is high and zero after reset.
    assign dout      = r_hold;
    assign done      = r_done;
    assign fail      = r_fail;
    assign retry_cnt = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hs_master_retry.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hs_master_retry
// Description : Directed self-checking bench for hs_master_retry with the
//               default parameters (DATA_W=32, MAX_RETRY=3, TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_master_retry;

    localparam int DATA_W    = 32;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;
    localparam int RETRY_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [DATA_W-1:0]  req_data;
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  dout;
    logic               response;
    logic               resp_err;
    logic               done;
    logic               fail;
    logic [RETRY_W-1:0] retry_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Running event counters, sampled on the active edge (pre-update values)
    int                xfer_cnt  = 0;
    int                done_cnt  = 0;
    int                fail_cnt  = 0;
    int                both_cnt  = 0;
    logic [DATA_W-1:0] last_xfer = '0;

    always #5 clk = ~clk;

    hs_master_retry #(
        .DATA_W    (DATA_W),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .valid     (valid),
        .ready     (ready),
        .dout      (dout),
        .response  (response),
        .resp_err  (resp_err),
        .done      (done),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always @(posedge clk) begin
        if (valid && ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= dout;
        end
        if (done)         done_cnt <= done_cnt + 1;
        if (fail)         fail_cnt <= fail_cnt + 1;
        if (done && fail) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word in IDLE; returns one cycle later in the SEND state.
    task automatic accept(input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_data  = d;
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL accept_req_ready: got %b, expected 1", req_ready); end
        step();
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("FAIL accept_busy: req_ready got %b, expected 0", req_ready); end
    endtask

    task automatic test_reset();
        int d0;
        step();
        n_checks++; if (valid !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin n_fails++; $display("FAIL rst_init_ctl: valid/done/fail got %b%b%b, expected 000", valid, done, fail); end
        n_checks++; if (dout !== 32'h0 || retry_cnt !== 2'd0) begin n_fails++; $display("FAIL rst_init_data: dout=%h retry=%0d, expected 0/0", dout, retry_cnt); end
        n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("FAIL rst_init_ready: got %b, expected 0", req_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL rst_release_ready: got %b, expected 1", req_ready); end
        step();
        // Abort a word in SEND
        ready = 1'b0;
        d0    = done_cnt + fail_cnt;
        accept(32'hDEADBEEF);
        n_checks++; if (valid !== 1'b1 || dout !== 32'hDEADBEEF) begin n_fails++; $display("FAIL rst_send: valid=%b dout=%h, expected 1/deadbeef", valid, dout); end
        step();
        reset = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0 || dout !== 32'h0) begin n_fails++; $display("FAIL rst_async_bus: valid=%b dout=%h, expected 0/0", valid, dout); end
        n_checks++; if (done !== 1'b0 || fail !== 1'b0 || retry_cnt !== 2'd0 || req_ready !== 1'b0) begin n_fails++; $display("FAIL rst_async_stat: done=%b fail=%b retry=%0d rdy=%b, expected 0/0/0/0", done, fail, retry_cnt, req_ready); end
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL rst_mid_release_ready: got %b, expected 1", req_ready); end
        // Stray responses in IDLE must be ignored
        response = 1'b1;
        resp_err = 1'b0;
        step();
        step();
        response = 1'b0;
        step();
        n_checks++; if (done_cnt + fail_cnt !== d0 || valid !== 1'b0) begin n_fails++; $display("FAIL rst_no_pulse: pulses=%0d valid=%b, expected 0/0", done_cnt + fail_cnt - d0, valid); end
    endtask

    task automatic test_clean();
        int x0, d0, f0;
        x0 = xfer_cnt; d0 = done_cnt; f0 = fail_cnt;
        ready = 1'b1;
        accept(32'h20220501);
        n_checks++; if (valid !== 1'b1 || dout !== 32'h20220501) begin n_fails++; $display("FAIL clean_send: valid=%b dout=%h, expected 1/20220501", valid, dout); end
        step();
        n_checks++; if (valid !== 1'b0 || xfer_cnt - x0 !== 1) begin n_fails++; $display("FAIL clean_one_cycle: valid=%b xfers=%0d, expected 0/1", valid, xfer_cnt - x0); end
        step();
        response = 1'b1; resp_err = 1'b0;
        step();
        response = 1'b0;
        n_checks++; if (done !== 1'b1 || fail !== 1'b0 || req_ready !== 1'b1) begin n_fails++; $display("FAIL clean_done: done=%b fail=%b rdy=%b, expected 1/0/1", done, fail, req_ready); end
        n_checks++; if (retry_cnt !== 2'd0) begin n_fails++; $display("FAIL clean_retry: got %0d, expected 0", retry_cnt); end
        step();
        n_checks++; if (done !== 1'b0 || done_cnt - d0 !== 1 || fail_cnt !== f0) begin n_fails++; $display("FAIL clean_pulse: done=%b dones=%0d fails=%0d, expected 0/1/0", done, done_cnt - d0, fail_cnt - f0); end
    endtask

    task automatic test_backpressure();
        int x0, d0;
        x0 = xfer_cnt; d0 = done_cnt;
        ready = 1'b0;
        accept(32'hCAFE0001);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (valid !== 1'b1 || dout !== 32'hCAFE0001) begin n_fails++; $display("FAIL bp_hold%0d: valid=%b dout=%h, expected 1/cafe0001", i, valid, dout); end
            step();
        end
        n_checks++; if (valid !== 1'b1 || dout !== 32'hCAFE0001 || xfer_cnt !== x0) begin n_fails++; $display("FAIL bp_sixth: valid=%b dout=%h xfers=%0d, expected 1/cafe0001/0", valid, dout, xfer_cnt - x0); end
        ready = 1'b1;
        step();
        n_checks++; if (valid !== 1'b0 || xfer_cnt - x0 !== 1 || last_xfer !== 32'hCAFE0001) begin n_fails++; $display("FAIL bp_xfer: valid=%b xfers=%0d data=%h, expected 0/1/cafe0001", valid, xfer_cnt - x0, last_xfer); end
        response = 1'b1; resp_err = 1'b0;
        step();
        response = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL bp_done: got %b, expected 1", done); end
        step();
        n_checks++; if (done_cnt - d0 !== 1) begin n_fails++; $display("FAIL bp_done_count: got %0d, expected 1", done_cnt - d0); end
    endtask

    task automatic test_nack_retry();
        int x0, d0, f0;
        x0 = xfer_cnt; d0 = done_cnt; f0 = fail_cnt;
        ready = 1'b1;
        accept(32'h5A5A0003);
        for (int a = 1; a <= 2; a++) begin
            step();
            response = 1'b1; resp_err = 1'b1;
            step();
            response = 1'b0; resp_err = 1'b0;
            n_checks++; if (valid !== 1'b1 || dout !== 32'h5A5A0003 || retry_cnt !== RETRY_W'(a)) begin n_fails++; $display("FAIL nack_resend%0d: valid=%b dout=%h retry=%0d, expected 1/5a5a0003/%0d", a, valid, dout, retry_cnt, a); end
        end
        step();
        response = 1'b1; resp_err = 1'b0;
        step();
        response = 1'b0;
        n_checks++; if (done !== 1'b1 || fail !== 1'b0 || retry_cnt !== 2'd2) begin n_fails++; $display("FAIL nack_done: done=%b fail=%b retry=%0d, expected 1/0/2", done, fail, retry_cnt); end
        step();
        n_checks++; if (xfer_cnt - x0 !== 3 || last_xfer !== 32'h5A5A0003) begin n_fails++; $display("FAIL nack_xfers: count=%0d data=%h, expected 3/5a5a0003", xfer_cnt - x0, last_xfer); end
        n_checks++; if (done_cnt - d0 !== 1 || fail_cnt !== f0 || retry_cnt !== 2'd2) begin n_fails++; $display("FAIL nack_pulses: dones=%0d fails=%0d retry=%0d, expected 1/0/2", done_cnt - d0, fail_cnt - f0, retry_cnt); end
    endtask

    task automatic test_timeout_exhaust();
        int x0, f0, n;
        x0 = xfer_cnt; f0 = fail_cnt;
        ready = 1'b1;
        accept(32'h7E570004);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            n_checks++; if (valid !== 1'b1 || dout !== 32'h7E570004) begin n_fails++; $display("FAIL to_send%0d: valid=%b dout=%h, expected 1/7e570004", a, valid, dout); end
            step();
            n = 0;
            while (!valid && !req_ready && n < 64) begin
                n++;
                step();
            end
            n_checks++; if (n !== TIMEOUT) begin n_fails++; $display("FAIL to_wait%0d: %0d WAIT_RESP cycles, expected %0d", a, n, TIMEOUT); end
        end
        n_checks++; if (fail !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1 || retry_cnt !== 2'd3) begin n_fails++; $display("FAIL to_fail: fail=%b done=%b rdy=%b retry=%0d, expected 1/0/1/3", fail, done, req_ready, retry_cnt); end
        step();
        n_checks++; if (xfer_cnt - x0 !== 4 || fail_cnt - f0 !== 1 || fail !== 1'b0 || retry_cnt !== 2'd3) begin n_fails++; $display("FAIL to_totals: xfers=%0d fails=%0d fail=%b retry=%0d, expected 4/1/0/3", xfer_cnt - x0, fail_cnt - f0, fail, retry_cnt); end
    endtask

    task automatic test_boundary();
        int x0, f0;
        // Ack in the last timer cycle
        x0 = xfer_cnt;
        ready = 1'b1;
        accept(32'hB0DA0005);
        step();
        repeat (TIMEOUT - 1) step();
        n_checks++; if (valid !== 1'b0 || req_ready !== 1'b0) begin n_fails++; $display("FAIL bnd_still_wait: valid=%b rdy=%b, expected 0/0", valid, req_ready); end
        response = 1'b1; resp_err = 1'b0;
        step();
        response = 1'b0;
        n_checks++; if (done !== 1'b1 || fail !== 1'b0 || retry_cnt !== 2'd0 || xfer_cnt - x0 !== 1) begin n_fails++; $display("FAIL bnd_ack: done=%b fail=%b retry=%0d xfers=%0d, expected 1/0/0/1", done, fail, retry_cnt, xfer_cnt - x0); end
        step();
        // Nack in the last timer cycle of the final attempt
        x0 = xfer_cnt; f0 = fail_cnt;
        accept(32'hB0DA0006);
        repeat (MAX_RETRY) begin
            step();
            response = 1'b1; resp_err = 1'b1;
            step();
            response = 1'b0; resp_err = 1'b0;
        end
        n_checks++; if (valid !== 1'b1 || retry_cnt !== 2'd3) begin n_fails++; $display("FAIL bnd_last_send: valid=%b retry=%0d, expected 1/3", valid, retry_cnt); end
        step();
        repeat (TIMEOUT - 1) step();
        response = 1'b1; resp_err = 1'b1;
        step();
        response = 1'b0; resp_err = 1'b0;
        n_checks++; if (fail !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1 || valid !== 1'b0) begin n_fails++; $display("FAIL bnd_nack: fail=%b done=%b rdy=%b valid=%b, expected 1/0/1/0", fail, done, req_ready, valid); end
        repeat (3) step();
        n_checks++; if (xfer_cnt - x0 !== 4 || fail_cnt - f0 !== 1 || valid !== 1'b0) begin n_fails++; $display("FAIL bnd_no_extra: xfers=%0d fails=%0d valid=%b, expected 4/1/0", xfer_cnt - x0, fail_cnt - f0, valid); end
    endtask

    task automatic test_back_to_back();
        int x0, d0;
        x0 = xfer_cnt; d0 = done_cnt;
        ready     = 1'b1;
        response  = 1'b1;   // held high: only the WAIT_RESP cycles may use it
        resp_err  = 1'b0;
        req_valid = 1'b1;
        req_data  = 32'h0B2B0007;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) req_data = 32'h0B2B0008;
            n_checks++; if (req_ready !== ((i % 3) == 0)) begin n_fails++; $display("FAIL b2b_ready%0d: got %b, expected %b", i, req_ready, ((i % 3) == 0)); end
            step();
        end
        req_valid = 1'b0;
        response  = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL b2b_done: got %b, expected 1", done); end
        step();
        n_checks++; if (xfer_cnt - x0 !== 2 || done_cnt - d0 !== 2 || last_xfer !== 32'h0B2B0008) begin n_fails++; $display("FAIL b2b_totals: xfers=%0d dones=%0d data=%h, expected 2/2/0b2b0008", xfer_cnt - x0, done_cnt - d0, last_xfer); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        ready     = 1'b0;
        response  = 1'b0;
        resp_err  = 1'b0;

        test_reset();
        test_clean();
        test_backpressure();
        test_nack_retry();
        test_timeout_exhaust();
        test_boundary();
        test_back_to_back();

        n_checks++; if (both_cnt !== 0) begin n_fails++; $display("FAIL done_and_fail: together %0d cycles, expected 0", both_cnt); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
